// File: rtl/apb_event_master_pkg.sv
// Shared types and constants for the event-to-APB write master.
package apb_event_pkg;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int TAG_W      = 8;

    // Width of a channel index; a single channel still needs one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_event_master_if.sv
// APB write-side bus bundle between the event master and one slave.
interface apb_event_master_if
    import apb_event_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);
    logic              psel_o;
    logic              penable_o;
    logic              pwrite_o;
    logic [ADDR_W-1:0] paddr_o;
    logic [DATA_W-1:0] pwdata_o;
    logic              pready_i;
    logic              pslverr_i;

    modport master (
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
        input  pready_i, pslverr_i
    );

    modport slave (
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
        output pready_i, pslverr_i
    );
endinterface

// File: rtl/apb_evt_arbiter.sv
// Fixed-priority or round-robin arbiter over the pending-event vector.
// The round-robin pointer only moves when the master actually takes a grant.
module apb_evt_arbiter
    import apb_event_pkg::*;
#(
    parameter int  NUM_EVT = 4,
    parameter int  RR_MODE = 0,
    localparam int IDX_W   = idx_width(NUM_EVT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_EVT-1:0] req,
    input  logic               advance,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W-1:0] last_grant_r;
    logic [IDX_W:0]   start_s;
    logic [IDX_W:0]   pos_s;
    logic             hit_s;
    logic             valid_s;
    logic [IDX_W-1:0] idx_s;

    // Search origin: channel 0 for fixed priority, one past the last grant for round-robin
    always_comb begin
        if (RR_MODE != 0) begin
            if (last_grant_r == IDX_W'(NUM_EVT - 1)) begin
                start_s = {(IDX_W+1){1'b0}};
            end else begin
                start_s = {1'b0, last_grant_r} + (IDX_W+1)'(1'b1);
            end
        end else begin
            start_s = {(IDX_W+1){1'b0}};
        end
    end

    // Walk the channels from the origin with wrap-around; first requester wins
    always_comb begin
        valid_s = 1'b0;
        idx_s   = {IDX_W{1'b0}};
        pos_s   = start_s;
        hit_s   = 1'b0;
        for (int i = 0; i < NUM_EVT; i++) begin
            pos_s   = start_s + (IDX_W+1)'(i);
            pos_s   = (pos_s >= (IDX_W+1)'(NUM_EVT)) ? (pos_s - (IDX_W+1)'(NUM_EVT)) : pos_s;
            hit_s   = ~valid_s & req[pos_s[IDX_W-1:0]];
            idx_s   = hit_s ? pos_s[IDX_W-1:0] : idx_s;
            valid_s = valid_s | hit_s;
        end
    end

    assign gnt_valid = valid_s;
    assign gnt_idx   = idx_s;

    // Remember the channel just taken; reset points at the top so channel 0 goes first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_r <= IDX_W'(NUM_EVT - 1);
        end else if (advance && valid_s) begin
            last_grant_r <= idx_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/apb_event_master.sv
// Event-to-APB write master: rising edges set pending bits, each granted
// channel gets one APB write of {channel tag, running count} to its own address.
module apb_event_master
    import apb_event_pkg::*;
#(
    parameter int              NUM_EVT     = 4,
    parameter int              ADDR_W      = APB_ADDR_W,
    parameter int              DATA_W      = APB_DATA_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
    parameter logic [ADDR_W-1:0] ADDR_STRIDE = 32'h0000_1000,
    parameter int              RR_MODE     = 0,
    localparam int             IDX_W       = idx_width(NUM_EVT),
    localparam int             CNT_W       = DATA_W - TAG_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_EVT-1:0]   event_i,
    input  logic                 err_clr_i,
    apb_event_master_if.master   apb,
    output logic [NUM_EVT-1:0]   pend_o,
    output logic                 ovf_o,
    output logic                 err_o,
    output logic [TAG_W-1:0]     err_ch_o
);

    apb_state_e         state_r, state_next_s;
    logic [NUM_EVT-1:0] evt_q_r, pend_r, rise_s, gmask_s, req_s, pend_next_s;
    logic [CNT_W-1:0]   cnt_r [NUM_EVT];
    logic [IDX_W-1:0]   ch_r, ch_next_s;
    logic               psel_r, penable_r, pwrite_r, ovf_r, err_r;
    logic               psel_next_s, penable_next_s, pwrite_next_s;
    logic [ADDR_W-1:0]  paddr_r, paddr_next_s, grant_addr_s;
    logic [DATA_W-1:0]  pwdata_r, pwdata_next_s, grant_data_s;
    logic [TAG_W-1:0]   err_ch_r;
    logic               complete_s, take_s, gnt_valid_s, err_set_s, ovf_next_s;
    logic [IDX_W-1:0]   gnt_idx_s;
    logic [CNT_W-1:0]   gnt_cnt_s;

    // Edge detect, completion mask and the request vector seen by the arbiter.
    // On completion the finishing channel only competes again if it re-rose this cycle.
    always_comb begin
        rise_s      = event_i & ~evt_q_r;
        complete_s  = (state_r == ACCESS) & apb.pready_i;
        gmask_s     = complete_s ? (NUM_EVT'(1'b1) << ch_r) : {NUM_EVT{1'b0}};
        pend_next_s = (pend_r & ~gmask_s) | rise_s;
        ovf_next_s  = |(rise_s & pend_r & ~gmask_s);
        err_set_s   = complete_s & apb.pslverr_i & (~err_r | err_clr_i);
        if (complete_s) begin
            req_s = (pend_r & ~gmask_s) | (rise_s & gmask_s);
        end else begin
            req_s = pend_r;
        end
    end

    apb_evt_arbiter #(
        .NUM_EVT (NUM_EVT),
        .RR_MODE (RR_MODE)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_s),
        .advance   (take_s),
        .gnt_valid (gnt_valid_s),
        .gnt_idx   (gnt_idx_s)
    );

    // Address and payload for the channel being granted; a channel re-granted
    // straight after its own completion already sees its incremented count
    always_comb begin
        grant_addr_s = BASE_ADDR + ADDR_W'(gnt_idx_s) * ADDR_STRIDE;
        if (complete_s && (gnt_idx_s == ch_r)) begin
            gnt_cnt_s = cnt_r[gnt_idx_s] + CNT_W'(1'b1);
        end else begin
            gnt_cnt_s = cnt_r[gnt_idx_s];
        end
        grant_data_s = {TAG_W'(gnt_idx_s), gnt_cnt_s};
    end

    // Sequencer next-state and next APB output values
    always_comb begin
        state_next_s   = state_r;
        psel_next_s    = psel_r;
        penable_next_s = penable_r;
        pwrite_next_s  = pwrite_r;
        paddr_next_s   = paddr_r;
        pwdata_next_s  = pwdata_r;
        ch_next_s      = ch_r;
        take_s         = 1'b0;
        case (state_r)
            IDLE, ACCESS: begin
                if ((state_r == IDLE || complete_s) && gnt_valid_s) begin
                    take_s         = 1'b1;
                    state_next_s   = SETUP;
                    psel_next_s    = 1'b1;
                    penable_next_s = 1'b0;
                    pwrite_next_s  = 1'b1;
                    paddr_next_s   = grant_addr_s;
                    pwdata_next_s  = grant_data_s;
                    ch_next_s      = gnt_idx_s;
                end else if (state_r == IDLE || complete_s) begin
                    state_next_s   = IDLE;
                    psel_next_s    = 1'b0;
                    penable_next_s = 1'b0;
                    pwrite_next_s  = 1'b0;
                end else begin
                    state_next_s   = ACCESS;
                end
            end
            SETUP: begin
                state_next_s   = ACCESS;
                penable_next_s = 1'b1;
            end
            default: begin
                state_next_s   = IDLE;
                psel_next_s    = 1'b0;
                penable_next_s = 1'b0;
                pwrite_next_s  = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered APB outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= {ADDR_W{1'b0}};
            pwdata_r  <= {DATA_W{1'b0}};
            ch_r      <= {IDX_W{1'b0}};
        end else begin
            state_r   <= state_next_s;
            psel_r    <= psel_next_s;
            penable_r <= penable_next_s;
            pwrite_r  <= pwrite_next_s;
            paddr_r   <= paddr_next_s;
            pwdata_r  <= pwdata_next_s;
            ch_r      <= ch_next_s;
        end
    end

    // Event history, pending bits and the overflow pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_q_r <= {NUM_EVT{1'b0}};
            pend_r  <= {NUM_EVT{1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            evt_q_r <= event_i;
            pend_r  <= pend_next_s;
            ovf_r   <= ovf_next_s;
        end
    end

    // Per-channel transfer counters, bumped on every completion including errored ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_EVT; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_EVT; i++) begin
                if (complete_s && (ch_r == IDX_W'(i))) begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1'b1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Sticky error flag recording the first failing channel; a new error beats a clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r    <= 1'b0;
            err_ch_r <= {TAG_W{1'b0}};
        end else if (err_set_s) begin
            err_r    <= 1'b1;
            err_ch_r <= TAG_W'(ch_r);
        end else if (err_clr_i) begin
            err_r    <= 1'b0;
            err_ch_r <= {TAG_W{1'b0}};
        end else begin
            err_r    <= err_r;
            err_ch_r <= err_ch_r;
        end
    end

    assign apb.psel_o    = psel_r;
    assign apb.penable_o = penable_r;
    assign apb.pwrite_o  = pwrite_r;
    assign apb.paddr_o   = paddr_r;
    assign apb.pwdata_o  = pwdata_r;
    assign pend_o        = pend_r;
    assign ovf_o         = ovf_r;
    assign err_o         = err_r;
    assign err_ch_o      = err_ch_r;

endmodule

// File: tb/tb_apb_event_master.sv
// Bench for apb_event_master: a fixed-priority and a round-robin instance share
// one stimulus stream; a transaction-level model predicts every output each cycle.
module tb_apb_event_master;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] ev = 4'b0000;
    logic       pready = 1'b0, pslverr = 1'b0, clr = 1'b0;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    apb_event_master_if #(.ADDR_W(32), .DATA_W(32)) bus_fx ();
    apb_event_master_if #(.ADDR_W(32), .DATA_W(32)) bus_rr ();
    assign bus_fx.pready_i  = pready;
    assign bus_fx.pslverr_i = pslverr;
    assign bus_rr.pready_i  = pready;
    assign bus_rr.pslverr_i = pslverr;

    logic [3:0] pend_fx, pend_rr;
    logic       ovf_fx, ovf_rr, err_fx, err_rr;
    logic [7:0] errch_fx, errch_rr;

    apb_event_master #(.NUM_EVT(4), .RR_MODE(0)) u_fx (
        .clk(clk), .rst(rst), .event_i(ev), .err_clr_i(clr), .apb(bus_fx),
        .pend_o(pend_fx), .ovf_o(ovf_fx), .err_o(err_fx), .err_ch_o(errch_fx));

    apb_event_master #(.NUM_EVT(4), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .event_i(ev), .err_clr_i(clr), .apb(bus_rr),
        .pend_o(pend_rr), .ovf_o(ovf_rr), .err_o(err_rr), .err_ch_o(errch_rr));

    // ---------------- reference model (index 0 = fixed, 1 = round-robin) ----------------
    int         m_phase [2];   // 0 no transfer, 1 address phase, 2 data phase
    int         m_g [2], m_last [2];
    int         m_cnt [2][4];
    logic [3:0] m_evq [2], m_pend [2];
    logic [31:0] m_addr [2], m_data [2];
    logic       m_ovf [2], m_err [2];
    logic [7:0] m_errch [2];

    task automatic mreset();
        for (int m = 0; m < 2; m++) begin
            m_phase[m] = 0; m_g[m] = 0; m_last[m] = 3;
            m_evq[m] = 4'b0000; m_pend[m] = 4'b0000;
            m_addr[m] = 32'h0; m_data[m] = 32'h0;
            m_ovf[m] = 1'b0; m_err[m] = 1'b0; m_errch[m] = 8'h00;
            for (int c = 0; c < 4; c++) m_cnt[m][c] = 0;
        end
    endtask

    function automatic int pick(int m, logic [3:0] req);
        int c;
        int r = -1;
        for (int k = 0; k < 4; k++) begin
            c = (m == 1) ? (m_last[m] + 1 + k) % 4 : k;
            if (r < 0 && req[c]) r = c;
        end
        return r;
    endfunction

    task automatic start_xfer(int m, int c);
        m_phase[m] = 1; m_g[m] = c; m_last[m] = c;
        m_addr[m]  = 32'h1000_0000 + 32'(c) * 32'h0000_1000;
        m_data[m]  = (32'(c) << 24) | 32'(m_cnt[m][c]);
    endtask

    task automatic mstep(int m);
        logic [3:0] rise, gmask, req;
        logic comp;
        int c;
        rise  = ev & ~m_evq[m];
        comp  = (m_phase[m] == 2) && pready;
        gmask = comp ? (4'b0001 << m_g[m]) : 4'b0000;
        m_ovf[m] = |(rise & m_pend[m] & ~gmask);
        req = m_pend[m];
        if (comp) begin
            m_cnt[m][m_g[m]] = (m_cnt[m][m_g[m]] + 1) % (1 << 24);
            req = (m_pend[m] & ~gmask) | (rise & gmask);
        end
        if (comp && pslverr && (!m_err[m] || clr)) begin
            m_err[m] = 1'b1; m_errch[m] = 8'(m_g[m]);
        end else if (clr) begin
            m_err[m] = 1'b0; m_errch[m] = 8'h00;
        end
        if (m_phase[m] == 1) begin
            m_phase[m] = 2;
        end else if (m_phase[m] == 0 || comp) begin
            c = pick(m, req);
            if (c >= 0) start_xfer(m, c);
            else m_phase[m] = 0;
        end
        m_pend[m] = (m_pend[m] & ~gmask) | rise;
        m_evq[m]  = ev;
    endtask

    function automatic logic [80:0] expv(int m);
        return {m_phase[m] != 0, m_phase[m] == 2, m_phase[m] != 0, m_addr[m], m_data[m],
                m_pend[m], m_ovf[m], m_err[m], m_errch[m]};
    endfunction

    function automatic logic [80:0] obs_fx();
        return {bus_fx.psel_o, bus_fx.penable_o, bus_fx.pwrite_o, bus_fx.paddr_o,
                bus_fx.pwdata_o, pend_fx, ovf_fx, err_fx, errch_fx};
    endfunction

    function automatic logic [80:0] obs_rr();
        return {bus_rr.psel_o, bus_rr.penable_o, bus_rr.pwrite_o, bus_rr.paddr_o,
                bus_rr.pwdata_o, pend_rr, ovf_rr, err_rr, errch_rr};
    endfunction

    task automatic chk(string tag, logic [95:0] obs, logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        mstep(0);
        mstep(1);
        #1;
        chk("cycle_fixed", obs_fx(), expv(0));
        chk("cycle_rr", obs_rr(), expv(1));
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        int ovf_cnt, ch1_done, ngot;
        int got [5];
        int exp_rr [5] = '{0, 1, 2, 3, 0};

        mreset();
        #12;
        chk("reset_fixed", obs_fx(), 96'h0);
        chk("reset_rr", obs_rr(), 96'h0);
        @(negedge clk) rst = 1'b1;
        tick();

        // Single ch2 event, two wait states
        ev = 4'b0100; pready = 1'b0; tick();
        ev = 4'b0000; tick();
        for (int i = 0; i < 4; i++) begin
            chk("wait_addr", bus_fx.paddr_o, 32'h1000_2000);
            chk("wait_data", bus_fx.pwdata_o, 32'h0200_0000);
            chk("wait_psel", bus_fx.psel_o, 1'b1);
            pready = (i == 3);
            tick();
        end
        chk("wait_idle", bus_fx.psel_o, 1'b0);
        ev = 4'b0100; tick();
        ev = 4'b0000; tick();
        chk("ch2_second_data", bus_fx.pwdata_o, 32'h0200_0001);
        tick(); tick();

        // ch0 and ch3 together, fixed priority back-to-back
        ev = 4'b1001; tick();
        ev = 4'b0000; tick();
        chk("b2b_first_addr", bus_fx.paddr_o, 32'h1000_0000);
        tick(); tick();
        chk("b2b_second_addr", bus_fx.paddr_o, 32'h1000_3000);
        chk("b2b_psel_held", {bus_fx.psel_o, bus_fx.penable_o}, 2'b10);
        tick(); tick();
        chk("b2b_idle", bus_fx.psel_o, 1'b0);

        // Overflow: ch1 re-pulsed while its transfer is stalled
        ovf_cnt = 0; ch1_done = 0;
        for (int s = 0; s < 9; s++) begin
            ev     = (s == 0 || s == 3) ? 4'b0010 : 4'b0000;
            pready = (s >= 5);
            if (bus_fx.psel_o && bus_fx.penable_o && pready && bus_fx.paddr_o == 32'h1000_1000)
                ch1_done++;
            tick();
            if (ovf_fx) ovf_cnt++;
        end
        chk("ovf_one_cycle", 32'(ovf_cnt), 32'd1);
        chk("ovf_one_xfer", 32'(ch1_done), 32'd1);

        // Slave error on ch3, later error on ch1, then clear
        ev = 4'b1000; tick();
        ev = 4'b0000; tick(); tick();
        pslverr = 1'b1; tick();
        pslverr = 1'b0;
        chk("err_set", {err_fx, errch_fx}, {1'b1, 8'd3});
        ev = 4'b1000; tick();
        ev = 4'b0000; tick();
        chk("err_cnt_incr", bus_fx.pwdata_o, 32'h0300_0002);
        tick(); tick();
        ev = 4'b0010; tick();
        ev = 4'b0000; tick(); tick();
        pslverr = 1'b1; tick();
        pslverr = 1'b0;
        chk("err_first_kept", {err_fx, errch_fx}, {1'b1, 8'd3});
        clr = 1'b1; tick();
        clr = 1'b0;
        chk("err_cleared", {err_fx, errch_fx}, 9'h000);

        // Reset in the middle of a data phase
        pready = 1'b0; ev = 4'b0100; tick();
        ev = 4'b0000; tick(); tick();
        #2 rst = 1'b0;
        #1;
        mreset();
        chk("midreset_fixed", obs_fx(), 96'h0);
        chk("midreset_rr", obs_rr(), 96'h0);
        @(negedge clk) rst = 1'b1;
        pready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_reset_quiet", bus_fx.psel_o, 1'b0);
        end

        // Round-robin with every channel kept pending
        for (int i = 0; i < 5; i++) got[i] = -1;
        ngot = 0;
        ev = 4'b1111; tick();
        ev = 4'b0000;
        for (int cyc = 0; cyc < 40 && ngot < 5; cyc++) begin
            if (bus_rr.psel_o && bus_rr.penable_o) begin
                got[ngot] = int'(bus_rr.paddr_o[13:12]);
                ngot++;
                ev = 4'b0001 << got[ngot-1];
            end else begin
                ev = 4'b0000;
            end
            tick();
        end
        if (ngot < 5) begin
            errors++;
            $error("FAIL rr_timeout observed=%0d grants expected=5", ngot);
        end
        for (int i = 0; i < 5; i++) chk("rr_order", 96'(got[i]), 96'(exp_rr[i]));
        ev = 4'b0000;
        repeat (20) tick();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            ev      = 4'($urandom);
            pready  = ($urandom_range(0, 3) != 0);
            pslverr = ($urandom_range(0, 7) == 0);
            clr     = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
